// File: rtl/a7_link_master.sv
// a7_link_master: serial command-bus master for the Artix7/Spartan6 link.
// Frames requests out on serial_out, deframes responses from serial_in.
//
// Ports:
//   clk, rst              fabric clock, async active-high reset
//   req_wr, req_rd        one-cycle request strobes (write wins)
//   req_addr, req_wrdata  request fields, sampled on accept
//   busy, done            transaction in flight / one-cycle completion
//   status, rddata        last response status byte and read data
//   timeout               last transaction timed out
//   serial_out, serial_in link wires
//   bytes_sent/seen       wrapping frame counters
module a7_link_master #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_wr,
    input  logic        req_rd,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wrdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  status,
    output logic [15:0] rddata,
    output logic        timeout,
    output logic        serial_out,
    input  logic        serial_in,
    output logic [15:0] bytes_sent,
    output logic [15:0] bytes_seen
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    state_t state, state_nx;

    logic          rx_q;
    logic [11:0]   rxsh;
    logic          rx_frame;
    logic          rx_cmd;
    logic [7:0]    rx_data;
    logic [64:0]   txsh;
    logic [64:0]   wr_seq;
    logic [64:0]   rd_seq;
    logic [6:0]    bitcnt;
    logic [TW-1:0] tcnt;
    logic [15:0]   acc;
    logic          accept;
    logic          term;
    logic          tmo;

    function automatic logic [12:0] frame(
        input logic       c,
        input logic [7:0] d
    );
        return {2'b01, c, d, 2'b00};
    endfunction

    // Sequences are left-aligned so both shift out of txsh[64].
    assign wr_seq = {frame(1'b0, req_wrdata[15:8]),
                     frame(1'b0, req_wrdata[7:0]),
                     frame(1'b0, req_addr[15:8]),
                     frame(1'b0, req_addr[7:0]),
                     frame(1'b1, 8'h01)};
    assign rd_seq = {frame(1'b0, req_addr[15:8]),
                     frame(1'b0, req_addr[7:0]),
                     frame(1'b1, 8'h02),
                     26'd0};

    // Start bit reaching the top with two trailing zeros marks a frame.
    assign rx_frame = rxsh[11] && (rxsh[1:0] == 2'b00);
    assign rx_cmd   = rxsh[10];
    assign rx_data  = rxsh[9:2];

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        term     = 1'b0;
        tmo      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_wr || req_rd) begin
                    accept   = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (bitcnt == 7'd0) state_nx = WAIT;
            end
            WAIT: begin
                // A terminating frame beats a simultaneous timeout.
                if (rx_frame && rx_cmd) begin
                    term     = 1'b1;
                    state_nx = IDLE;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    tmo      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done       <= 1'b0;
            status     <= 8'h00;
            rddata     <= 16'h0000;
            timeout    <= 1'b0;
            serial_out <= 1'b0;
            bytes_sent <= 16'h0000;
            bytes_seen <= 16'h0000;
            rx_q       <= 1'b0;
            rxsh       <= 12'h000;
            txsh       <= '0;
            bitcnt     <= 7'd0;
            tcnt       <= '0;
            acc        <= 16'h0000;
        end else begin
            done <= term || tmo;
            rx_q <= serial_in;
            // The bit arriving on a frame edge is the next leading 0.
            rxsh <= rx_frame ? 12'h000 : {rxsh[10:0], rx_q};
            if (rx_frame) bytes_seen <= bytes_seen + 16'd1;

            if (accept) begin
                timeout <= 1'b0;
                acc     <= 16'h0000;
                if (req_wr) begin
                    txsh       <= wr_seq;
                    bitcnt     <= 7'd65;
                    bytes_sent <= bytes_sent + 16'd5;
                end else begin
                    txsh       <= rd_seq;
                    bitcnt     <= 7'd39;
                    bytes_sent <= bytes_sent + 16'd3;
                end
            end

            if (state == SEND) begin
                if (bitcnt != 7'd0) begin
                    serial_out <= txsh[64];
                    txsh       <= {txsh[63:0], 1'b0};
                    bitcnt     <= bitcnt - 7'd1;
                end else begin
                    serial_out <= 1'b0;
                    tcnt       <= '0;
                end
            end

            if (state == WAIT) begin
                tcnt <= tcnt + 1'b1;
                if (rx_frame && !rx_cmd) acc <= {acc[7:0], rx_data};
                if (term) begin
                    status <= rx_data;
                    rddata <= acc;
                end else if (tmo) begin
                    status  <= 8'hFF;
                    rddata  <= 16'h0000;
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_a7_link_master.sv
// tb_a7_link_master: directed bench for the serial link master.
// Main instance uses the default timeout; a second one uses 20.
module tb_a7_link_master;

    logic        clk;
    logic        rst;
    logic        req_wr, req_rd;
    logic [15:0] req_addr, req_wrdata;
    logic        busy, done, timeout, serial_out, serial_in;
    logic [7:0]  status;
    logic [15:0] rddata, bytes_sent, bytes_seen;

    logic        t_req_wr, t_req_rd;
    logic [15:0] t_req_addr, t_req_wrdata;
    logic        t_busy, t_done, t_timeout, t_serial_out, t_serial_in;
    logic [7:0]  t_status;
    logic [15:0] t_rddata, t_bytes_sent, t_bytes_seen;

    int ncmp  = 0;
    int nfail = 0;

    a7_link_master dut (
        .clk        (clk),
        .rst        (rst),
        .req_wr     (req_wr),
        .req_rd     (req_rd),
        .req_addr   (req_addr),
        .req_wrdata (req_wrdata),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .rddata     (rddata),
        .timeout    (timeout),
        .serial_out (serial_out),
        .serial_in  (serial_in),
        .bytes_sent (bytes_sent),
        .bytes_seen (bytes_seen)
    );

    a7_link_master #(.TIMEOUT(20)) dut_t (
        .clk        (clk),
        .rst        (rst),
        .req_wr     (t_req_wr),
        .req_rd     (t_req_rd),
        .req_addr   (t_req_addr),
        .req_wrdata (t_req_wrdata),
        .busy       (t_busy),
        .done       (t_done),
        .status     (t_status),
        .rddata     (t_rddata),
        .timeout    (t_timeout),
        .serial_out (t_serial_out),
        .serial_in  (t_serial_in),
        .bytes_sent (t_bytes_sent),
        .bytes_seen (t_bytes_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] frm(input logic c,
                                        input logic [7:0] d);
        return {2'b01, c, d, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic c, input logic [7:0] d);
        logic [12:0] f;
        f = frm(c, d);
        for (int i = 12; i >= 0; i--) begin
            serial_in = f[i];
            tick();
        end
        serial_in = 1'b0;
    endtask

    task automatic capture(input int n, output logic [64:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            v = {v[63:0], serial_out};
        end
    endtask

    // Last frame is the terminator; done must appear two edges later.
    task automatic finish_check(input string tag);
        chk({tag, "_done_n0"}, done, 1'b0);
        tick();
        chk({tag, "_done_n1"}, done, 1'b0);
        tick();
        chk({tag, "_done_n2"}, done, 1'b1);
        chk({tag, "_busy_end"}, busy, 1'b0);
    endtask

    logic [64:0] cap;
    logic [64:0] exp65;

    initial begin
        rst = 1'b1;
        req_wr = 0; req_rd = 0; req_addr = 0; req_wrdata = 0;
        serial_in = 0;
        t_req_wr = 0; t_req_rd = 0; t_req_addr = 0;
        t_req_wrdata = 0; t_serial_in = 0;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_status", status, 8'h00);
        chk("rst_rddata", rddata, 16'h0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_sout", serial_out, 1'b0);
        chk("rst_sent", bytes_sent, 16'h0);
        chk("rst_seen", bytes_seen, 16'h0);
        rst = 1'b0;
        tick();

        // Write addr 0003 data 1234
        req_wr = 1; req_addr = 16'h0003; req_wrdata = 16'h1234;
        tick();
        req_wr = 0;
        chk("wr_busy", busy, 1'b1);
        chk("wr_sent", bytes_sent, 16'd5);
        chk("wr_sout_e0", serial_out, 1'b0);
        capture(65, cap);
        exp65 = {3'b010, 8'h12, 2'b00, 3'b010, 8'h34, 2'b00,
                 3'b010, 8'h00, 2'b00, 3'b010, 8'h03, 2'b00,
                 3'b011, 8'h01, 2'b00};
        chk("wr_bits", cap, exp65);
        send_frame(1'b0, 8'h00);
        send_frame(1'b0, 8'h00);
        chk("wr_sout_idle", serial_out, 1'b0);
        send_frame(1'b1, 8'h01);
        finish_check("wr");
        chk("wr_status", status, 8'h01);
        chk("wr_rddata", rddata, 16'h0000);
        chk("wr_seen", bytes_seen, 16'd3);
        chk("wr_timeout", timeout, 1'b0);
        tick();
        chk("wr_done_pulse", done, 1'b0);

        // Read addr 0001 returning beef
        req_rd = 1; req_addr = 16'h0001;
        tick();
        req_rd = 0;
        chk("rd_sent", bytes_sent, 16'd8);
        capture(39, cap);
        exp65 = {26'd0, frm(0, 8'h00), frm(0, 8'h01),
                 frm(1, 8'h02)};
        chk("rd_bits", cap, exp65);
        send_frame(1'b0, 8'hbe);
        send_frame(1'b0, 8'hef);
        send_frame(1'b1, 8'h02);
        finish_check("rd");
        chk("rd_status", status, 8'h02);
        chk("rd_rddata", rddata, 16'hbeef);
        chk("rd_seen", bytes_seen, 16'd6);
        tick();

        // Write and read together, then a read while busy
        req_wr = 1; req_rd = 1;
        req_addr = 16'h00A5; req_wrdata = 16'h5A5A;
        tick();
        req_wr = 0; req_rd = 0;
        chk("both_sent", bytes_sent, 16'd13);
        cap = '0;
        for (int i = 0; i < 65; i++) begin
            req_rd = (i == 9);
            tick();
            cap = {cap[63:0], serial_out};
        end
        req_rd = 0;
        exp65 = {frm(0, 8'h5A), frm(0, 8'h5A), frm(0, 8'h00),
                 frm(0, 8'hA5), frm(1, 8'h01)};
        chk("both_bits", cap, exp65);
        chk("both_sent_busy", bytes_sent, 16'd13);
        send_frame(1'b1, 8'h01);
        finish_check("both");
        chk("both_rddata", rddata, 16'h0000);
        repeat (3) tick();
        chk("both_idle", busy, 1'b0);
        chk("both_sent_end", bytes_sent, 16'd13);

        // Stray frame while idle
        send_frame(1'b1, 8'h77);
        tick();
        chk("stray_done1", done, 1'b0);
        tick();
        chk("stray_done2", done, 1'b0);
        chk("stray_seen", bytes_seen, 16'd8);
        chk("stray_status", status, 8'h01);
        chk("stray_sent", bytes_sent, 16'd13);

        // Reset 30 cycles into a write
        req_wr = 1; req_addr = 16'h8000; req_wrdata = 16'h0000;
        tick();
        req_wr = 0;
        repeat (30) tick();
        chk("rw_sout_hi", serial_out, 1'b1);
        rst = 1'b1;
        #1;
        chk("rw_busy", busy, 1'b0);
        chk("rw_sout", serial_out, 1'b0);
        chk("rw_sent", bytes_sent, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rw_no_done", done, 1'b0);
        end
        rst = 1'b0;
        tick();
        req_rd = 1; req_addr = 16'h0002;
        tick();
        req_rd = 0;
        capture(39, cap);
        exp65 = {26'd0, frm(0, 8'h00), frm(0, 8'h02),
                 frm(1, 8'h02)};
        chk("rr_bits", cap, exp65);
        send_frame(1'b0, 8'h12);
        send_frame(1'b0, 8'h34);
        send_frame(1'b1, 8'h02);
        finish_check("rr");
        chk("rr_rddata", rddata, 16'h1234);
        chk("rr_status", status, 8'h02);
        chk("rr_seen", bytes_seen, 16'd3);
        chk("rr_sent", bytes_sent, 16'd3);

        // Timeout instance: silent responder
        t_req_rd = 1; t_req_addr = 16'h0001;
        tick();
        t_req_rd = 0;
        chk("to_busy", t_busy, 1'b1);
        repeat (40) tick();
        chk("to_timeout_wait", t_timeout, 1'b0);
        repeat (19) tick();
        chk("to_done_early", t_done, 1'b0);
        tick();
        chk("to_done", t_done, 1'b1);
        chk("to_status", t_status, 8'hFF);
        chk("to_flag", t_timeout, 1'b1);
        chk("to_rddata", t_rddata, 16'h0000);
        chk("to_busy_end", t_busy, 1'b0);
        tick();
        chk("to_pulse", t_done, 1'b0);
        chk("to_flag_hold", t_timeout, 1'b1);
        t_req_wr = 1; t_req_addr = 16'h0004;
        tick();
        t_req_wr = 0;
        chk("to_clear", t_timeout, 1'b0);
        chk("to_busy2", t_busy, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/a7_link_master.md
# a7_link_master

Serial-link master for the Microzed-to-Artix7/Spartan6 command bus. It sits directly downstream of the AXI-lite register-bus decode and consumes its one-cycle `do_a7_write`/`do_a7_read` strobes. It serializes each request into framed 9-bit "bytes" on a single output wire, deframes the response stream from the remote bus FSM, and returns status plus read data with a completion pulse and a timeout. It replaces the ad-hoc shift/collect logic in `myverilog` with one self-contained, handshaked block.

## Interface
- `TIMEOUT`, 1023: cycles allowed between the last transmitted bit and the terminating response byte.
- `clk` input 1: fabric clock (Zynq fclk0); all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_wr` input 1: one-cycle write request strobe.
- `req_rd` input 1: one-cycle read request strobe.
- `req_addr` input 16: remote bus address, sampled on accept.
- `req_wrdata` input 16: write data, sampled on accept.
- `busy` output 1: high from the accept edge until the edge that raises `done`.
- `done` output 1: one-cycle pulse when a transaction completes or times out.
- `status` output 8: last response status byte; `8'hFF` after a timeout.
- `rddata` output 16: read data from the last response.
- `timeout` output 1: high while the last transaction timed out; cleared on the next accept.
- `serial_out` output 1: registered serial line to the remote side.
- `serial_in` input 1: serial line from the remote side.
- `bytes_sent` output 16: count of transmitted frames, wraps.
- `bytes_seen` output 16: count of received frames, wraps.

## Operation
- Tx frame is 13 bits, MSB first: `0, 1, C, d7..d0, 0, 0`. C=1 marks the command byte.
- Write sequence, 5 frames, 65 bits: wrdata[15:8], wrdata[7:0], addr[15:8], addr[7:0], then `8'h01` with C=1.
- Read sequence, 3 frames, 39 bits: addr[15:8], addr[7:0], then `8'h02` with C=1.
- FSM states:
  - IDLE: accept a request and go to SEND.
  - SEND: shift the frames out. After the last bit, go to WAIT.
  - WAIT: on a terminating byte or on timeout, pulse `done` and go to IDLE.
- If `req_wr` and `req_rd` are high together, the write wins. Requests that arrive while `busy` is high are ignored and have no other effect.
- `bytes_sent` increments by 5 (write) or 3 (read) on the accept edge.
- Rx path:
  - `serial_in` is registered once, then shifted into a 12-bit register `rxsh`.
  - When `rxsh[11]==1 && rxsh[1:0]==0`, a frame is complete: data = `rxsh[9:2]`, C = `rxsh[10]`. `rxsh` clears on that edge and the incoming bit is dropped.
  - Every completed frame increments `bytes_seen`, whatever the FSM state.
- In WAIT:
  - A frame with C=0 shifts into a 16-bit accumulator: `acc <= {acc[7:0], data}`.
  - A frame with C=1 loads `status <= data` and `rddata <= acc`, and sets `done`.
  - `acc` clears on accept.
- Frames that arrive outside WAIT are counted and discarded.
- Timeout: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches `TIMEOUT`, the block sets `status=8'hFF`, `rddata=0`, `timeout=1`, pulses `done`, and goes to IDLE.
- A terminating frame on the same edge as the timeout wins, so the transaction completes normally.

## Timing
- Reset values: `busy=0`, `done=0`, `status=0`, `rddata=0`, `timeout=0`, `serial_out=0`, both counters 0, FSM in IDLE, `rxsh=0`.
- Reset asserted mid-transaction aborts it: no `done` pulse, and `serial_out` returns to 0 immediately.
- Accept edge E0: the request is sampled, `busy` rises, and the tx shift register is loaded. Frame bit 0 appears on `serial_out` after E1. The final bit appears after E65 (write) or E39 (read).
- WAIT is entered on the edge after the final bit is launched.
- Receive latency: a terminating frame whose final `0` is on `serial_in` before edge N gives `done=1`, with valid `status`/`rddata`, after edge N+2. The same edge clears `busy`.
- Back-to-back operation: a new request is accepted in the cycle after `done` at the earliest.
- `serial_out` idles low. `bytes_sent` and `bytes_seen` wrap modulo 2^16.

## Test plan
- Write addr `16'h0003`, data `16'h1234`: `serial_out` carries 65 bits `0 1 0 00010010 00`, `0 1 0 00110100 00`, `0 1 0 00000000 00`, `0 1 0 00000011 00`, `0 1 1 00000001 00`. `bytes_sent=5`. Loopback responder returns `00,00` then C=1 `8'h01`: expect `done` with `status=8'h01`, `rddata=0`.
- Read addr `16'h0001`: 39 bits sent. Responder returns `be`, `ef`, then C=1 `8'h02`: expect `rddata=16'hbeef`, `status=8'h02`, `bytes_seen` up by 3.
- Read with a silent responder and `TIMEOUT=20`: `done` arrives 20 cycles after WAIT entry, with `status=8'hFF`, `timeout=1`, `rddata=0`. The next request clears `timeout`.
- `req_wr` and `req_rd` in the same cycle, then `req_rd` 10 cycles later: one write sequence only, and `bytes_sent` increments by 5 total.
- Stray frame injected while IDLE: `bytes_sent` and `status` unchanged, `bytes_seen` increments.
- Assert `rst` 30 cycles into a write: `busy=0` and `serial_out=0` immediately, no `done`, and a following read completes normally.
